// File: rtl/spi_pixel_tx_if.sv
// Pixel word stream between an upstream source and the SPI transmitter.
// Valid/ready: a word moves on a rising edge where pixel_valid and pixel_ready are both high;
// the source holds pixel_data and pixel_valid stable until that edge.
interface spi_pixel_tx_if;
  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/spi_pixel_tx.sv
// SPI mode-0 master that shifts 32-bit pixel words MSB-first and tracks word position
// within a frame buffer, pulsing frame_done when the last word of a frame completes.
module spi_pixel_tx #(
  parameter  int CLK_DIV     = 4,
  parameter  int FRAME_WORDS = 2048,
  localparam int WCW         = $clog2(FRAME_WORDS)
) (
  input  logic           sys_clk,
  input  logic           reset,
  spi_pixel_tx_if.slave  pix,
  output logic           spi_clk,
  output logic           spi_mosi,
  output logic           busy,
  output logic [WCW-1:0] word_count,
  output logic           frame_done,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [WCW-1:0] WC_ONE   = WCW'(1);

  state_t         r_state;
  state_t         w_state_next;
  logic [31:0]    r_shift;
  logic [4:0]     r_bit;
  logic [7:0]     r_div;
  logic           r_spi_clk;
  logic [WCW-1:0] r_word_count;
  logic           r_frame_done;

  logic           w_accept;
  logic           w_div_done;
  logic           w_shift;
  logic           w_word_done;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    w_word_done  = 1'b0;
    w_div_done   = (r_div == DIV_LAST);
    case (r_state)
      S_IDLE: begin
        if (pix.pixel_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (w_div_done) begin
          w_state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_div_done) begin
          if (r_bit == 5'd0) begin
            w_word_done  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_shift      = 1'b1;
            w_state_next = S_LOW;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The MSB of the shift register is the line itself; it only moves on entry to LOW,
  // and after the last bit it is left unshifted so the line holds bit 0 while idle.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_shift      <= 32'd0;
      r_bit        <= 5'd0;
      r_div        <= 8'd0;
      r_spi_clk    <= 1'b0;
      r_word_count <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_spi_clk    <= (w_state_next == S_HIGH);
      r_frame_done <= w_word_done && (&r_word_count);
      if (w_accept) begin
        r_shift <= pix.pixel_data;
        r_bit   <= 5'd31;
        r_div   <= 8'd0;
      end else if (r_state != S_IDLE) begin
        r_div <= w_div_done ? 8'd0 : (r_div + 8'd1);
      end
      if (w_shift) begin
        r_shift <= {r_shift[30:0], 1'b0};
        r_bit   <= r_bit - 5'd1;
      end
      if (w_word_done) begin
        r_word_count <= r_word_count + WC_ONE;
      end
    end
  end

  assign pix.pixel_ready = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign spi_clk         = r_spi_clk;
  assign spi_mosi        = r_shift[31];
  assign word_count      = r_word_count;
  assign frame_done      = r_frame_done;
  assign state_dbg       = r_state;

endmodule

// File: tb/tb_spi_pixel_tx.sv
// Directed bench for spi_pixel_tx: three instances (CLK_DIV 4/1/255) share clock and reset,
// a slave model captures bits on spi_clk rising edges, and each step asserts hand-computed values.
module tb_spi_pixel_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_v [3];
  logic [2:0]  valid_v = '0;
  logic [2:0]  rdy, sclk, smosi, busy_v, fd;
  logic [10:0] wc_a, wc_c;
  logic [1:0]  wc_b;
  logic [1:0]  st_a, st_b, st_c;

  int errors = 0;
  int checks = 0;

  int          rises    [3] = '{default: 0};
  int          last_run [3] = '{default: 0};
  int          run      [3] = '{default: 0};
  int          viol     [3] = '{default: 0};
  int          fd_cnt   [3] = '{default: 0};
  logic [31:0] cap      [3] = '{default: 32'd0};
  logic [2:0]  prev_clk  = '0;
  logic [2:0]  prev_mosi = '0;

  always #5 clk = ~clk;

  spi_pixel_tx_if if_a ();
  spi_pixel_tx_if if_b ();
  spi_pixel_tx_if if_c ();

  assign if_a.pixel_data  = data_v[0];
  assign if_b.pixel_data  = data_v[1];
  assign if_c.pixel_data  = data_v[2];
  assign if_a.pixel_valid = valid_v[0];
  assign if_b.pixel_valid = valid_v[1];
  assign if_c.pixel_valid = valid_v[2];
  assign rdy[0] = if_a.pixel_ready;
  assign rdy[1] = if_b.pixel_ready;
  assign rdy[2] = if_c.pixel_ready;

  spi_pixel_tx #(.CLK_DIV(4), .FRAME_WORDS(2048)) u_a (
    .sys_clk(clk), .reset(rst), .pix(if_a),
    .spi_clk(sclk[0]), .spi_mosi(smosi[0]), .busy(busy_v[0]),
    .word_count(wc_a), .frame_done(fd[0]), .state_dbg(st_a)
  );

  spi_pixel_tx #(.CLK_DIV(1), .FRAME_WORDS(4)) u_b (
    .sys_clk(clk), .reset(rst), .pix(if_b),
    .spi_clk(sclk[1]), .spi_mosi(smosi[1]), .busy(busy_v[1]),
    .word_count(wc_b), .frame_done(fd[1]), .state_dbg(st_b)
  );

  spi_pixel_tx #(.CLK_DIV(255), .FRAME_WORDS(2048)) u_c (
    .sys_clk(clk), .reset(rst), .pix(if_c),
    .spi_clk(sclk[2]), .spi_mosi(smosi[2]), .busy(busy_v[2]),
    .word_count(wc_c), .frame_done(fd[2]), .state_dbg(st_c)
  );

  // Slave model: capture on rising spi_clk, track low-run length, flag MOSI moving while high.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sclk[i] && !prev_clk[i]) begin
        last_run[i] = run[i];
        cap[i]      = {cap[i][30:0], smosi[i]};
        rises[i]    = rises[i] + 1;
      end
      if (sclk[i] && prev_clk[i] && (smosi[i] !== prev_mosi[i])) viol[i] = viol[i] + 1;
      run[i] = sclk[i] ? 0 : run[i] + 1;
      if (fd[i]) fd_cnt[i] = fd_cnt[i] + 1;
      prev_clk[i]  = sclk[i];
      prev_mosi[i] = smosi[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts negedge samples with pixel_ready low, stopping at the first ready sample or the bound.
  task automatic wait_ready(input int idx, input int bound, output int n);
    n = 0;
    @(negedge clk);
    while (!rdy[idx] && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  int          n, lo, hi, tot, r0, f0;
  longint      t0, t1;
  logic [1:0]  exp_wc [9] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic        exp_fd [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 3; i++) data_v[i] = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_sclk_a",  {31'd0, sclk[0]},   32'd0);
    check("rst_mosi_a",  {31'd0, smosi[0]},  32'd0);
    check("rst_ready_a", {31'd0, rdy[0]},    32'd1);
    check("rst_busy_a",  {31'd0, busy_v[0]}, 32'd0);
    check("rst_wc_a",    {21'd0, wc_a},      32'd0);
    check("rst_fd_a",    {31'd0, fd[0]},     32'd0);
    check("rst_wc_b",    {30'd0, wc_b},      32'd0);
    rst = 1'b0;

    // Back-to-back on the CLK_DIV=1 instance with valid held high.
    data_v[1] = 32'hFFFF_FFFF;
    valid_v[1] = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1 data_v[1] = 32'h0000_0000;
    wait_ready(1, 200, n);
    check("b2b_busy_cycles", n, 32'd64);
    check("b2b_cap_w0", cap[1], 32'hFFFF_FFFF);
    @(posedge clk);
    t1 = $time;
    check("b2b_accept_gap", 32'((t1 - t0) / 10), 32'd65);
    n = 0;
    @(negedge clk);
    while (!sclk[1] && n < 10) begin
      n++;
      @(negedge clk);
    end
    #1;
    check("b2b_low_gap_ge2", {31'd0, (last_run[1] >= 2)}, 32'd1);
    valid_v[1] = 1'b0;
    wait_ready(1, 200, n);
    check("b2b_cap_w1", cap[1], 32'h0000_0000);
    check("b2b_wc", {30'd0, wc_b}, 32'd2);

    // Frame wrap with FRAME_WORDS=4 over nine words.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    f0 = fd_cnt[1];
    for (int i = 0; i < 9; i++) begin
      data_v[1] = 32'h1111_1111 * 32'(i + 1);
      valid_v[1] = 1'b1;
      @(posedge clk);
      #1 valid_v[1] = 1'b0;
      wait_ready(1, 200, n);
      check($sformatf("wrap_cap_%0d", i), cap[1], 32'h1111_1111 * 32'(i + 1));
      check($sformatf("wrap_wc_%0d", i), {30'd0, wc_b}, {30'd0, exp_wc[i]});
      check($sformatf("wrap_fd_%0d", i), {31'd0, fd[1]}, {31'd0, exp_fd[i]});
    end
    check("wrap_fd_pulses", 32'(fd_cnt[1] - f0), 32'd2);

    // Single word on the CLK_DIV=4 instance.
    r0 = rises[0];
    data_v[0] = 32'hA5C3_0F81;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    wait_ready(0, 1000, n);
    check("single_ready_low", n, 32'd256);
    check("single_cap", cap[0], 32'hA5C3_0F81);
    check("single_rises", 32'(rises[0] - r0), 32'd32);
    check("single_wc", {21'd0, wc_a}, 32'd1);
    check("single_idle_mosi", {31'd0, smosi[0]}, 32'd1);

    // Stall: source changes data mid-word; the latched word must be unaffected.
    data_v[0] = 32'h1234_5678;
    valid_v[0] = 1'b1;
    @(posedge clk);
    repeat (50) @(negedge clk);
    data_v[0] = 32'hDEAD_BEEF;
    wait_ready(0, 1000, n);
    check("stall_cap_w0", cap[0], 32'h1234_5678);
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    wait_ready(0, 1000, n);
    check("stall_cap_w1", cap[0], 32'hDEAD_BEEF);
    check("stall_wc", {21'd0, wc_a}, 32'd3);

    // CLK_DIV=255 single word.
    data_v[2] = 32'h8000_0001;
    valid_v[2] = 1'b1;
    @(posedge clk);
    #1 valid_v[2] = 1'b0;
    lo = 0;
    @(negedge clk);
    while (!sclk[2] && lo < 1000) begin
      lo++;
      @(negedge clk);
    end
    hi = 0;
    while (sclk[2] && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    tot = lo + hi;
    while (!rdy[2] && tot < 20000) begin
      tot++;
      @(negedge clk);
    end
    check("div255_low_half", lo, 32'd255);
    check("div255_high_half", hi, 32'd255);
    check("div255_word_cycles", tot, 32'd16320);
    check("div255_cap", cap[2], 32'h8000_0001);

    // Reset mid-word on the CLK_DIV=4 instance, with valid held through reset.
    data_v[0] = 32'hA5C3_0F81;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", {31'd0, busy_v[0]}, 32'd1);
    data_v[0] = 32'hF0F0_F0F0;
    valid_v[0] = 1'b1;
    rst = 1'b1;
    #1;
    check("rstmid_sclk",  {31'd0, sclk[0]},  32'd0);
    check("rstmid_mosi",  {31'd0, smosi[0]}, 32'd0);
    check("rstmid_ready", {31'd0, rdy[0]},   32'd1);
    check("rstmid_wc",    {21'd0, wc_a},     32'd0);
    r0 = rises[0];
    repeat (3) @(negedge clk);
    check("rstmid_no_edges", 32'(rises[0] - r0), 32'd0);
    check("rstmid_busy", {31'd0, busy_v[0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    @(negedge clk);
    check("post_rst_accept", {31'd0, busy_v[0]}, 32'd1);
    check("post_rst_mosi", {31'd0, smosi[0]}, 32'd1);
    wait_ready(0, 1000, n);
    check("post_rst_cap", cap[0], 32'hF0F0_F0F0);
    check("post_rst_wc", {21'd0, wc_a}, 32'd1);

    for (int i = 0; i < 3; i++) check($sformatf("mosi_stable_hi_%0d", i), viol[i], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_pixel_tx.md
# spi_pixel_tx

Transmit-side SPI master for the matrix display link: accepts 32-bit pixel words from an upstream source (frame generator, test pattern engine or host bridge) over a valid/ready handshake and serialises them MSB-first on spi_clk/spi_mosi to the panel controller's SPI slave. It tracks word position within a frame buffer (2048 words, the controller's buffer depth) and flags each completed frame, so the controller's double-buffer flip stays aligned with the source.

## Interface

Parameters:
- CLK_DIV, 4: sys_clk cycles per spi_clk half-period; legal range 1..255.
- FRAME_WORDS, 2048: words per frame buffer; power of two, 2..4096.

Ports:
- sys_clk  in  1  block clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_data  in  32  word to send; bit 31 transmitted first.
- pixel_valid  in  1  source has a word on pixel_data.
- pixel_ready  out  1  block can accept a word this cycle.
- spi_clk  out  1  SPI clock, mode 0 (idles low, data sampled by slave on rising edge).
- spi_mosi  out  1  SPI data.
- busy  out  1  high while a word is being shifted.
- word_count  out  log2(FRAME_WORDS)  index of next word within the frame.
- frame_done  out  1  one-cycle pulse when the last word of a frame finishes.

## Operation

- States: IDLE, LOW, HIGH.
- IDLE: pixel_ready=1, spi_clk=0, busy=0. On pixel_valid & pixel_ready at an edge: latch pixel_data into 32-bit shift register, bit counter=31, divider=0, go LOW.
- LOW: spi_clk=0, spi_mosi=shift[31]. After CLK_DIV cycles go HIGH.
- HIGH: spi_clk=1, spi_mosi held. After CLK_DIV cycles: if bit counter=0, word complete -> IDLE; else shift left by 1, decrement bit counter, -> LOW.
- spi_mosi changes only on entry to LOW (never while spi_clk=1).
- Word complete: word_count increments modulo FRAME_WORDS; if word_count was FRAME_WORDS-1 it wraps to 0 and frame_done pulses in the same cycle as the return to IDLE.
- pixel_ready is 0 in LOW and HIGH; no word queuing, source holds pixel_data/pixel_valid until accepted.
- pixel_data changes while not ready are ignored.
- spi_mosi in IDLE holds last transmitted bit (bit 0 of previous word); 0 after reset.

## Timing

- Reset (async, immediate): state IDLE, spi_clk=0, spi_mosi=0, pixel_ready=1, busy=0, word_count=0, frame_done=0, shift register and counters cleared.
- Accept edge T: from T+1, spi_mosi=bit31, spi_clk=0 for CLK_DIV cycles; rising spi_clk at T+1+CLK_DIV.
- Bit n occupies 2*CLK_DIV cycles (low then high); word occupies exactly 64*CLK_DIV cycles from T+1.
- IDLE re-entered at T+1+64*CLK_DIV; pixel_ready=1 that cycle; earliest next accept same edge, giving at least one sys_clk of spi_clk low between words (inter-word gap 1 cycle + CLK_DIV).
- Sustained throughput: one word per 64*CLK_DIV+1 cycles.
- frame_done and word_count update on the IDLE re-entry edge.
- Reset mid-word: output stops at once with spi_clk low; receiver sees a partial word, so the system drives the controller's reset from the same source. No recovery beyond reset.
- pixel_valid asserted during reset is ignored; first accept on first edge after reset deasserts.

## Test plan

- Reset values: assert reset mid-shift of a word with CLK_DIV=4 -> spi_clk=0, spi_mosi=0, pixel_ready=1, word_count=0 within the same cycle, no further spi_clk edges.
- Single word 0xA5C3_0F81, CLK_DIV=4 -> slave model sampling on spi_clk rising edges captures 0xA5C3_0F81; exactly 32 rising edges; pixel_ready low for 256 cycles; spi_mosi never changes while spi_clk=1.
- Back-to-back words 0xFFFF_FFFF then 0x0000_0000 with pixel_valid held high, CLK_DIV=1 -> both captured in order; second accept 65 cycles after first; spi_clk low for >=2 cycles between words.
- Handshake stall: assert pixel_valid with 0x1234_5678, change pixel_data to 0xDEAD_BEEF mid-word -> first word 0x1234_5678, then 0xDEAD_BEEF accepted on next ready.
- Frame wrap with FRAME_WORDS=4: send 9 words -> frame_done pulses exactly twice (after words 4 and 8), word_count sequence 1,2,3,0,1,2,3,0,1.
- CLK_DIV=255 single word 0x8000_0001 -> spi_clk half-period 255 cycles; word completes 16320 cycles after accept+1; captured value correct.
